ram_sp_ctrl: RTL and testbench

Parametrised single-port synchronous RAM with a shared bidirectional data bus. It generalises the fixed 32x32 RAM in width and depth. It adds a post-reset zero-clear sequencer, a busy indication and a registered read with a valid strobe. The RAM drives the shared bus only during its valid cycle, so there is no bus contention. It sits as the data-memory block on the shared bus, between the CPU-side datapath and the board-level memory tests.

---
 rtl/ram_sp_ctrl_if.sv | 21 ++
 rtl/ram_sp_ctrl.sv | 94 +++++++++
 tb/tb_ram_sp_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_sp_ctrl_if.sv
// Control bus for ram_sp_ctrl: request, address and status strobes.
// The per-lane write enable exists only when RAM_BYTE_WE_EN is defined.
interface ram_sp_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  ena;
  logic                  wena;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  busy;
  logic                  rd_valid;
`ifdef RAM_BYTE_WE_EN
  logic [DATA_WIDTH/8-1:0] be;

  modport master (output ena, wena, addr, be, input busy, rd_valid);
  modport slave  (input ena, wena, addr, be, output busy, rd_valid);
`else
  modport master (output ena, wena, addr, input busy, rd_valid);
  modport slave  (input ena, wena, addr, output busy, rd_valid);
`endif
endinterface

// File: rtl/ram_sp_ctrl.sv
// Single-port RAM on a shared tristate bus with a post-reset zero sweep and 1-cycle
// registered read. Optional byte-lane writes via RAM_BYTE_WE_EN.
module ram_sp_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_sp_ctrl_if.slave          bus,
  inout  wire  [DATA_WIDTH-1:0] data
);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
`ifdef RAM_BYTE_WE_EN
  localparam int unsigned NumBytes = DATA_WIDTH / 8;
`endif

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
`ifdef RAM_BYTE_WE_EN
  logic [NumBytes-1:0]   wbe;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    rd_d       = rd_q;
    we         = 1'b0;
    waddr      = bus.addr;
    wdata      = data;
`ifdef RAM_BYTE_WE_EN
    wbe        = bus.be;
`endif
    if (rst) begin
      state_d = StClear;
      cnt_d   = '0;
      rd_d    = '0;
    end else begin
      unique case (state_q)
        StClear: begin
          we    = 1'b1;
          waddr = cnt_q;
          wdata = '0;
`ifdef RAM_BYTE_WE_EN
          wbe   = '1;
`endif
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) state_d = StReady;
        end
        StReady: begin
          if (bus.ena) begin
            if (bus.wena) begin
              // While rd_valid is high the bus carries our own read data.
              we = 1'b1;
            end else begin
              rd_d       = mem_q[bus.addr];
              rd_valid_d = 1'b1;
            end
          end
        end
        default: state_d = StClear;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    cnt_q      <= cnt_d;
    rd_valid_q <= rd_valid_d;
    rd_q       <= rd_d;
    if (we) begin
`ifdef RAM_BYTE_WE_EN
      for (int i = 0; i < NumBytes; i++) begin
        if (wbe[i]) mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
`else
      mem_q[waddr] <= wdata;
`endif
    end
  end

  assign bus.busy     = (state_q == StClear);
  assign bus.rd_valid = rd_valid_q;
  assign data         = rd_valid_q ? rd_q : {DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Directed self-checking bench for ram_sp_ctrl (default 32x32 geometry).
module tb_ram_sp_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          tb_oe;
  logic [DW-1:0] tb_dout;
  wire  [DW-1:0] data;

  int n_checks = 0;
  int n_pass   = 0;

  ram_sp_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  ram_sp_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_if.slave),
    .data (data)
  );

  assign data = tb_oe ? tb_dout : {DW{1'bz}};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts the cycles busy stays high, bounded so a stuck clear cannot hang.
  task automatic count_busy(output int n);
    n = 0;
    while (bus_if.busy && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic idle();
    bus_if.ena  = 1'b0;
    bus_if.wena = 1'b0;
    tb_oe       = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_if.ena  = 1'b1;
    bus_if.wena = 1'b1;
    bus_if.addr = a;
    tb_oe       = 1'b1;
    tb_dout     = d;
    step();
    idle();
  endtask

  task automatic rd_req(input logic [AW-1:0] a);
    tb_oe       = 1'b0;
    bus_if.ena  = 1'b1;
    bus_if.wena = 1'b0;
    bus_if.addr = a;
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    bus_if.addr = '0;
`ifdef RAM_BYTE_WE_EN
    bus_if.be   = '1;
`endif
    tb_dout     = '0;
    idle();
    step();
    rst = 1'b0;
    check("rst_rd_valid", {31'b0, bus_if.rd_valid}, 32'd0);
    check("rst_busy", {31'b0, bus_if.busy}, 32'd1);

    // Clear sweep, with a write attempt at clear cycle 4 that must be ignored.
    n = 0;
    while (bus_if.busy && n < 200) begin
      if (n == 4) begin
        bus_if.ena  = 1'b1;
        bus_if.wena = 1'b1;
        bus_if.addr = 5'd3;
        tb_oe       = 1'b1;
        tb_dout     = 32'h1234_5678;
      end else begin
        idle();
      end
      n++;
      step();
    end
    idle();
    check("clear_len", n, 32'd32);

    for (int a = 0; a < 32; a++) begin
      rd_req(AW'(a));
      step();
      check($sformatf("zero_rv_%0d", a), {31'b0, bus_if.rd_valid}, 32'd1);
      check($sformatf("zero_data_%0d", a), data, 32'h0);
    end
    idle();
    step();
    check("zero_rv_end", {31'b0, bus_if.rd_valid}, 32'd0);

    wr(5'd5, 32'hDEAD_BEEF);
    check("wr_rv", {31'b0, bus_if.rd_valid}, 32'd0);
    rd_req(5'd5);
    step();
    check("rd5_rv", {31'b0, bus_if.rd_valid}, 32'd1);
    check("rd5_data", data, 32'hDEAD_BEEF);
    idle();
    step();
    check("rd5_rv_drop", {31'b0, bus_if.rd_valid}, 32'd0);
    tb_oe   = 1'b1;
    tb_dout = 32'h0;
    #1;
    check("bus_released", data, 32'h0);
    idle();

    wr(5'd1, 32'h11);
    wr(5'd2, 32'h22);
    wr(5'd3, 32'h33);
    rd_req(5'd1);
    step();
    check("b2b_rv1", {31'b0, bus_if.rd_valid}, 32'd1);
    check("b2b_d1", data, 32'h11);
    rd_req(5'd2);
    step();
    check("b2b_rv2", {31'b0, bus_if.rd_valid}, 32'd1);
    check("b2b_d2", data, 32'h22);
    rd_req(5'd3);
    step();
    check("b2b_rv3", {31'b0, bus_if.rd_valid}, 32'd1);
    check("b2b_d3", data, 32'h33);
    idle();
    step();
    check("b2b_rv_end", {31'b0, bus_if.rd_valid}, 32'd0);

    // Write while the RAM still drives its read data: stores that data.
    rd_req(5'd5);
    step();
    bus_if.ena  = 1'b1;
    bus_if.wena = 1'b1;
    bus_if.addr = 5'd9;
    step();
    rd_req(5'd9);
    step();
    check("turn_wr_data", data, 32'hDEAD_BEEF);
    idle();
    step();

`ifdef RAM_BYTE_WE_EN
    bus_if.be = 4'b1111;
    wr(5'd7, 32'hFFFF_FFFF);
    bus_if.be = 4'b0101;
    wr(5'd7, 32'h0000_0000);
    bus_if.be = 4'b1111;
    rd_req(5'd7);
    step();
    check("be_data", data, 32'hFF00_FF00);
    idle();
    step();
`endif

    // Reset mid-clear restarts the full sweep.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(n);
    check("reclear_len", n, 32'd32);
    rd_req(5'd5);
    step();
    check("reclear_data5", data, 32'h0);
    idle();
    step();

    // Reset on the same edge as a read request.
    wr(5'd2, 32'h77);
    rd_req(5'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    check("rst_rd_rv", {31'b0, bus_if.rd_valid}, 32'd0);
    tb_oe   = 1'b1;
    tb_dout = 32'h0;
    #1;
    check("rst_rd_bus", data, 32'h0);
    idle();
    count_busy(n);
    check("rst_rd_clear_len", n, 32'd32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
